// File: rtl/bomb_pkg.sv
// ----------------------------------------------------------------------------
// bomb_pkg
// Shared definitions for the bomb fuse manager: the per-slot state encoding,
// the tile coordinate widths and the default fuse length in frame ticks.
// ----------------------------------------------------------------------------
package bomb_pkg;

    localparam int COL_W = 5;
    localparam int ROW_W = 4;

    localparam logic [7:0] FUSE_FRAMES_DEFAULT = 8'd120;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_ARMED   = 2'd1,
        SLOT_EXPIRED = 2'd2
    } slot_state_t;

endpackage

// File: rtl/bomb_slot.sv
// ----------------------------------------------------------------------------
// bomb_slot
// One live-bomb slot: state (IDLE/ARMED/EXPIRED), latched tile, fuse counter.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   load                    arm this slot with place_col/place_row (only
//                           honoured while IDLE)
//   place_col, place_row    tile of the bomb being placed; also the tile
//                           compared for duplicate detection
//   frame_tick              fuse time base
//   chain_valid/col/row     flame covering a tile; an ARMED slot on that
//                           tile expires immediately
//   clear                   detonation accepted; EXPIRED slot returns to IDLE
//   state, col, row         current slot contents
//   tile_match              slot is occupied and holds place_col/place_row
// ----------------------------------------------------------------------------
module bomb_slot
    import bomb_pkg::*;
#(
    parameter logic [7:0] FUSE_FRAMES = FUSE_FRAMES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [COL_W-1:0] place_col,
    input  logic [ROW_W-1:0] place_row,
    input  logic             frame_tick,
    input  logic             chain_valid,
    input  logic [COL_W-1:0] chain_col,
    input  logic [ROW_W-1:0] chain_row,
    input  logic             clear,
    output slot_state_t      state,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             tile_match
);

    slot_state_t      state_reg;
    logic [7:0]       fuse_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             chain_hit;

    assign chain_hit  = chain_valid && (state_reg == SLOT_ARMED) &&
                        (col_reg == chain_col) && (row_reg == chain_row);

    // EXPIRED slots still occupy their tile until the blast is emitted.
    assign tile_match = (state_reg != SLOT_IDLE) &&
                        (col_reg == place_col) && (row_reg == place_row);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SLOT_IDLE;
            fuse_reg  <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            case (state_reg)
                SLOT_IDLE: begin
                    // A fresh bomb ignores a coincident frame_tick.
                    if (load) begin
                        state_reg <= SLOT_ARMED;
                        fuse_reg  <= FUSE_FRAMES;
                        col_reg   <= place_col;
                        row_reg   <= place_row;
                    end
                end
                SLOT_ARMED: begin
                    if (chain_hit) begin
                        state_reg <= SLOT_EXPIRED;
                        fuse_reg  <= '0;
                    end else if (frame_tick) begin
                        // <= 1 rather than == 1 so the counter can never wrap.
                        if (fuse_reg <= 8'd1) begin
                            state_reg <= SLOT_EXPIRED;
                            fuse_reg  <= '0;
                        end else begin
                            fuse_reg <= fuse_reg - 8'd1;
                        end
                    end
                end
                SLOT_EXPIRED: begin
                    if (clear) begin
                        state_reg <= SLOT_IDLE;
                        col_reg   <= '0;
                        row_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= SLOT_IDLE;
                end
            endcase
        end
    end

    assign state = state_reg;
    assign col   = col_reg;
    assign row   = row_reg;

endmodule

// File: rtl/bomb_fuse_manager.sv
// ----------------------------------------------------------------------------
// bomb_fuse_manager
// Tracks up to NUM_SLOTS live bombs, counts their fuses down on frame_tick,
// handles chain reactions and emits one registered blast per cycle.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   frame_tick               one pulse per video frame (fuse time base)
//   place_req/col/row        placement request for a tile
//   chain_valid/col/row      flame covering a tile
//   place_ack/place_reject   registered response to place_req
//   blast, blast_col/row     registered detonation pulse and its tile
//   active_mask              bit i set while slot i is ARMED or EXPIRED
// ----------------------------------------------------------------------------
module bomb_fuse_manager
    import bomb_pkg::*;
#(
    parameter int         NUM_SLOTS   = 4,
    parameter logic [7:0] FUSE_FRAMES = FUSE_FRAMES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 place_req,
    input  logic [COL_W-1:0]     place_col,
    input  logic [ROW_W-1:0]     place_row,
    input  logic                 chain_valid,
    input  logic [COL_W-1:0]     chain_col,
    input  logic [ROW_W-1:0]     chain_row,
    output logic                 place_ack,
    output logic                 place_reject,
    output logic                 blast,
    output logic [COL_W-1:0]     blast_col,
    output logic [ROW_W-1:0]     blast_row,
    output logic [NUM_SLOTS-1:0] active_mask
);

    slot_state_t          slot_state [NUM_SLOTS];
    logic [COL_W-1:0]     slot_col   [NUM_SLOTS];
    logic [ROW_W-1:0]     slot_row   [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] idle_vec;
    logic [NUM_SLOTS-1:0] expired_vec;
    logic [NUM_SLOTS-1:0] dup_vec;
    logic [NUM_SLOTS-1:0] load_vec;
    logic [NUM_SLOTS-1:0] clear_vec;

    logic                 place_accept;
    logic                 place_refuse;
    logic [COL_W-1:0]     pick_col;
    logic [ROW_W-1:0]     pick_row;

    logic                 place_ack_reg;
    logic                 place_reject_reg;
    logic                 blast_reg;
    logic [COL_W-1:0]     blast_col_reg;
    logic [ROW_W-1:0]     blast_row_reg;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            bomb_slot #(
                .FUSE_FRAMES (FUSE_FRAMES)
            ) u_slot (
                .clk         (clk),
                .reset       (reset),
                .load        (load_vec[gi]),
                .place_col   (place_col),
                .place_row   (place_row),
                .frame_tick  (frame_tick),
                .chain_valid (chain_valid),
                .chain_col   (chain_col),
                .chain_row   (chain_row),
                .clear       (clear_vec[gi]),
                .state       (slot_state[gi]),
                .col         (slot_col[gi]),
                .row         (slot_row[gi]),
                .tile_match  (dup_vec[gi])
            );

            assign idle_vec[gi]    = (slot_state[gi] == SLOT_IDLE);
            assign expired_vec[gi] = (slot_state[gi] == SLOT_EXPIRED);
            assign active_mask[gi] = !idle_vec[gi];
        end
    endgenerate

    // Occupancy comes from registered slot state, so a slot blasting this
    // cycle still counts as occupied until the next one.
    assign place_accept = place_req && (|idle_vec) && !(|dup_vec);
    assign place_refuse = place_req && !place_accept;

    // x & -x isolates the lowest set bit: lowest-index priority pick.
    assign load_vec  = place_accept ? (idle_vec & (~idle_vec + NUM_SLOTS'(1)))
                                    : '0;
    assign clear_vec = expired_vec & (~expired_vec + NUM_SLOTS'(1));

    always_comb begin
        pick_col = '0;
        pick_row = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (clear_vec[i]) begin
                pick_col = slot_col[i];
                pick_row = slot_row[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            place_ack_reg    <= 1'b0;
            place_reject_reg <= 1'b0;
            blast_reg        <= 1'b0;
            blast_col_reg    <= '0;
            blast_row_reg    <= '0;
        end else begin
            place_ack_reg    <= place_accept;
            place_reject_reg <= place_refuse;
            blast_reg        <= |expired_vec;
            blast_col_reg    <= pick_col;
            blast_row_reg    <= pick_row;
        end
    end

    assign place_ack    = place_ack_reg;
    assign place_reject = place_reject_reg;
    assign blast        = blast_reg;
    assign blast_col    = blast_col_reg;
    assign blast_row    = blast_row_reg;

endmodule

// File: tb/tb_bomb_fuse_manager.sv
// ----------------------------------------------------------------------------
// tb_bomb_fuse_manager
// Scoreboard bench: each placement pushes its expected ack/reject, each
// detonation the bench causes pushes its expected tile and arrival cycle;
// negedge monitors pop and compare as the DUT responds.
// ----------------------------------------------------------------------------
module tb_bomb_fuse_manager;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       place_req;
    logic [4:0] place_col;
    logic [3:0] place_row;
    logic       chain_valid;
    logic [4:0] chain_col;
    logic [3:0] chain_row;
    logic       place_ack;
    logic       place_reject;
    logic       blast;
    logic [4:0] blast_col;
    logic [3:0] blast_row;
    logic [3:0] active_mask;

    bomb_fuse_manager dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .place_req    (place_req),
        .place_col    (place_col),
        .place_row    (place_row),
        .chain_valid  (chain_valid),
        .chain_col    (chain_col),
        .chain_row    (chain_row),
        .place_ack    (place_ack),
        .place_reject (place_reject),
        .blast        (blast),
        .blast_col    (blast_col),
        .blast_row    (blast_row),
        .active_mask  (active_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] col;
        logic [3:0] row;
        int         cyc;
    } blast_exp_t;

    blast_exp_t blast_q[$];
    bit         place_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit req_d  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        req_d <= place_req && !reset;
    end

    // Placement response monitor
    always @(negedge clk) begin
        bit exp_ack;
        if (req_d) begin
            if (place_q.size() == 0) begin
                check("place_q_underflow", 1, 0);
            end else begin
                exp_ack = place_q.pop_front();
                check("place_ack", place_ack, exp_ack);
                check("place_reject", place_reject, !exp_ack);
                $display("place resp cyc=%0d ack=%0d reject=%0d exp_ack=%0d",
                         cyc, place_ack, place_reject, exp_ack);
            end
        end else if (place_ack || place_reject) begin
            check("spurious_place_resp", {place_ack, place_reject}, 0);
        end
    end

    // Blast monitor
    always @(negedge clk) begin
        blast_exp_t e;
        if (blast) begin
            if (blast_q.size() == 0) begin
                check("unexpected_blast", 1, 0);
            end else begin
                e = blast_q.pop_front();
                check("blast_col", blast_col, e.col);
                check("blast_row", blast_row, e.row);
                check("blast_cycle", cyc, e.cyc);
                $display("blast cyc=%0d tile=(%0d,%0d) exp=(%0d,%0d)@%0d",
                         cyc, blast_col, blast_row, e.col, e.row, e.cyc);
            end
        end else if (blast_col != 0 || blast_row != 0) begin
            check("blast_coord_idle", {blast_col, blast_row}, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input logic [4:0] c, input logic [3:0] r, input bit exp_ack);
        place_req = 1'b1;
        place_col = c;
        place_row = r;
        place_q.push_back(exp_ack);
        step();
        place_req = 1'b0;
    endtask

    task automatic chain(input logic [4:0] c, input logic [3:0] r, input bit exp_blast);
        blast_exp_t e;
        chain_valid = 1'b1;
        chain_col   = c;
        chain_row   = r;
        if (exp_blast) begin
            e.col = c; e.row = r; e.cyc = cyc + 2;
            blast_q.push_back(e);
        end
        step();
        chain_valid = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic expect_blast(input logic [4:0] c, input logic [3:0] r, input int at);
        blast_exp_t e;
        e.col = c; e.row = r; e.cyc = at;
        blast_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; place_req = 1'b0;
        place_col = '0; place_row = '0;
        chain_valid = 1'b0; chain_col = '0; chain_row = '0;
        repeat (3) step();
        check("rst_mask", active_mask, 0);
        check("rst_ack", place_ack, 0);
        check("rst_reject", place_reject, 0);
        check("rst_blast", blast, 0);
        check("rst_blast_col", blast_col, 0);
        check("rst_blast_row", blast_row, 0);
        reset = 1'b0;
        step();

        // A: place at (3,2) together with a tick; that tick must not count.
        frame_tick = 1'b1;
        place(5'd3, 4'd2, 1'b1);
        frame_tick = 1'b0;
        check("A_mask_armed", active_mask, 4'b0001);
        tick_n(119);
        check("A_mask_tick119", active_mask, 4'b0001);
        expect_blast(5'd3, 4'd2, cyc + 2);
        tick_n(1);
        repeat (3) step();
        check("A_mask_after", active_mask, 4'b0000);

        // B: fill all slots, overflow, duplicate, reuse timing of a freed slot.
        place(5'd1, 4'd1, 1'b1);
        place(5'd2, 4'd1, 1'b1);
        place(5'd3, 4'd1, 1'b1);
        place(5'd4, 4'd1, 1'b1);
        place(5'd5, 4'd1, 1'b0);
        check("B_mask_full", active_mask, 4'b1111);
        place(5'd2, 4'd1, 1'b0);
        chain(5'd1, 4'd1, 1'b1);
        place(5'd9, 4'd9, 1'b0);   // slot 0 still EXPIRED this cycle
        check("B_mask_freed", active_mask, 4'b1110);
        place(5'd9, 4'd9, 1'b1);
        check("B_mask_reused", active_mask, 4'b1111);

        // Reset with live bombs and a coincident place_req: nothing survives.
        reset = 1'b1; place_req = 1'b1; place_col = 5'd9; place_row = 4'd8;
        step();
        reset = 1'b0; place_req = 1'b0;
        check("B_rst_mask", active_mask, 0);
        check("B_rst_ack", place_ack, 0);
        tick_n(130);
        check("B_rst_mask_late", active_mask, 0);

        // C: same tile twice.
        place(5'd7, 4'd5, 1'b1);
        place(5'd7, 4'd5, 1'b0);
        check("C_mask", active_mask, 4'b0001);
        chain(5'd7, 4'd5, 1'b1);
        repeat (2) step();
        check("C_mask_after", active_mask, 0);

        // D: slots 0 and 2 expire on the same tick.
        place(5'd10, 4'd3, 1'b1);
        place(5'd11, 4'd3, 1'b1);
        place(5'd12, 4'd3, 1'b1);
        chain(5'd11, 4'd3, 1'b1);
        repeat (2) step();
        check("D_mask_pre", active_mask, 4'b0101);
        tick_n(119);
        expect_blast(5'd10, 4'd3, cyc + 2);
        expect_blast(5'd12, 4'd3, cyc + 3);
        tick_n(1);
        step();
        check("D_mask_mid", active_mask, 4'b0100);
        step();
        check("D_mask_after", active_mask, 0);

        // E: chain reaction mid-fuse; partial tile matches must not fire.
        place(5'd4, 4'd4, 1'b1);
        place(5'd6, 4'd6, 1'b1);
        place(5'd4, 4'd7, 1'b1);
        tick_n(60);
        chain(5'd6, 4'd4, 1'b0);
        repeat (2) step();
        check("E_mask_nomatch", active_mask, 4'b0111);
        chain(5'd4, 4'd4, 1'b1);
        step();
        check("E_mask_after", active_mask, 4'b0110);
        do_reset();

        // F: three armed bombs discarded by reset mid-fuse.
        place(5'd1, 4'd2, 1'b1);
        place(5'd2, 4'd2, 1'b1);
        place(5'd3, 4'd2, 1'b1);
        tick_n(50);
        check("F_mask_armed", active_mask, 4'b0111);
        do_reset();
        check("F_rst_mask", active_mask, 0);
        tick_n(130);
        check("F_mask_late", active_mask, 0);
        place(5'd5, 4'd5, 1'b1);
        check("F_mask_new", active_mask, 4'b0001);
        do_reset();
        repeat (4) step();

        check("blast_q_empty", blast_q.size(), 0);
        check("place_q_empty", place_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
